// File: rtl/clken_nco.sv
// ============================================================================
// Module   : clken_nco
// Brief    : Multi-channel NCO clock-enable generator. Each channel has a
//            phase accumulator with staged, glitch-free rate updates and a
//            lock delay after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clken_nco #(
  parameter int NCH         = 2,
  parameter int ACCW        = 16,
  parameter int DEF_INC     = 2 ** (ACCW - 1),
  parameter int LOCK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [2:0]      wr_ch,
  input  logic [ACCW:0]   wr_inc,
  input  logic            sync,
  output logic [NCH-1:0]  ce,
  output logic [NCH-1:0]  pending,
  output logic            locked
);

  localparam logic [ACCW:0] c_MAX_INC = {1'b1, {ACCW{1'b0}}};
  localparam logic [ACCW:0] c_DEF_INC =
    (DEF_INC > 2 ** ACCW) ? c_MAX_INC : (ACCW + 1)'(DEF_INC);
  localparam int            c_CNTW    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(LOCK_CYCLES - 1);

  localparam logic [1:0] S_RESET   = 2'd0;
  localparam logic [1:0] S_LOCKING = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [c_CNTW-1:0] r_lock_cnt;
  logic              w_locked;
  logic              w_wr_ok;
  logic [ACCW:0]     w_wr_inc;

  // Lock sequencer: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Lock sequencer: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:   w_state_next = (r_lock_cnt == c_LAST) ? S_RUN : S_LOCKING;
      S_LOCKING: w_state_next = (r_lock_cnt == c_LAST) ? S_RUN : S_LOCKING;
      S_RUN:     w_state_next = S_RUN;
      default:   w_state_next = S_RESET;
    endcase
  end

  // Lock sequencer: outputs
  always_comb begin
    w_locked = 1'b0;
    if (r_state == S_RUN) begin
      w_locked = 1'b1;
    end
  end

  // The counter only needs to advance until the run state is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
    end else if (r_state != S_RUN && r_lock_cnt != c_LAST) begin
      r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  assign locked   = w_locked;
  assign w_wr_ok  = wr_en && ({1'b0, wr_ch} < 4'(NCH));
  assign w_wr_inc = (wr_inc > c_MAX_INC) ? c_MAX_INC : wr_inc;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [ACCW-1:0] r_acc;
    logic [ACCW:0]   r_inc;
    logic [ACCW:0]   r_pinc;
    logic            r_pend;
    logic            r_ce;
    logic [ACCW:0]   w_sum;
    logic            w_carry;
    logic            w_sel;
    logic            w_apply;

    assign w_sum   = {1'b0, r_acc} + r_inc;
    assign w_carry = w_sum[ACCW];
    assign w_sel   = w_wr_ok && (wr_ch == 3'(gi));

    // A staged rate is swapped in only at a wrap, on sync, or when the
    // channel is idle, so the output never sees a shortened period.
    always_comb begin
      w_apply = 1'b0;
      if (r_pend) begin
        if (!w_locked) begin
          w_apply = 1'b1;
        end else begin
          w_apply = sync || w_carry || (r_inc == '0);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc  <= '0;
        r_inc  <= c_DEF_INC;
        r_pinc <= c_DEF_INC;
        r_pend <= 1'b0;
        r_ce   <= 1'b0;
      end else begin
        if (w_apply) begin
          r_inc <= r_pinc;
        end
        // A write coinciding with an apply stays pending for the next wrap
        if (w_sel) begin
          r_pinc <= w_wr_inc;
          r_pend <= 1'b1;
        end else if (w_apply) begin
          r_pend <= 1'b0;
        end
        if (!w_locked || sync) begin
          r_acc <= '0;
          r_ce  <= 1'b0;
        end else begin
          r_acc <= w_sum[ACCW-1:0];
          r_ce  <= w_carry;
        end
      end
    end

    assign ce[gi]      = r_ce;
    assign pending[gi] = r_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_clken_nco.sv
// ============================================================================
// Module   : tb_clken_nco
// Brief    : Directed self-checking bench for clken_nco (NCH=2, ACCW=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clken_nco;

  localparam int NCH  = 2;
  localparam int ACCW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [2:0]      wr_ch;
  logic [ACCW:0]   wr_inc;
  logic            sync;
  logic [NCH-1:0]  ce;
  logic [NCH-1:0]  pending;
  logic            locked;

  int n_checks = 0;
  int n_errors = 0;

  clken_nco #(
    .NCH         (NCH),
    .ACCW        (ACCW),
    .DEF_INC     (8),
    .LOCK_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_inc  (wr_inc),
    .sync    (sync),
    .ce      (ce),
    .pending (pending),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [ACCW:0] inc);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_inc = inc;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_inc = '0; sync = 1'b0;
    tick(); tick();
    chk("rst_ce", 32'(ce), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_locked", 32'(locked), 0);
    rst = 1'b0;

    // Lock delay: locked on the 4th edge after release, no pulses before
    tick(); tick(); tick();
    chk("lock_e3", 32'(locked), 0);
    chk("ce_prelock", 32'(ce), 0);
    tick();
    chk("lock_e4", 32'(locked), 1);
    tick(); chk("def_e5", 32'(ce), 2'b00);
    tick(); chk("def_e6", 32'(ce), 2'b11);
    tick(); chk("def_e7", 32'(ce), 2'b00);
    tick(); chk("def_e8", 32'(ce), 2'b11);

    // ch1 inc=16: fires every cycle once applied at its next wrap
    wr(1, 16);
    tick(); chk("w16_pend", 32'(pending), 2'b10); chk("w16_e9", 32'(ce), 2'b00);
    wr_en = 1'b0;
    tick(); chk("w16_e10", 32'(ce), 2'b11); chk("w16_applied", 32'(pending), 0);
    tick(); chk("w16_e11", 32'(ce), 2'b10);
    tick(); chk("w16_e12", 32'(ce), 2'b11);
    tick(); chk("w16_e13", 32'(ce), 2'b10);

    // wr_inc=31 clamps to 16
    wr(1, 31);
    tick(); chk("w31_e14", 32'(ce), 2'b11); chk("w31_pend", 32'(pending), 2'b10);
    wr_en = 1'b0;
    tick(); chk("w31_e15", 32'(ce), 2'b10); chk("w31_applied", 32'(pending), 0);
    tick(); chk("w31_e16", 32'(ce), 2'b11);
    tick(); chk("w31_e17", 32'(ce), 2'b10);

    // Back to 8 on ch1: phase after the clamped period shows acc stayed 0
    wr(1, 8);
    tick(); chk("w8_e18", 32'(ce), 2'b11); chk("w8_pend", 32'(pending), 2'b10);
    wr_en = 1'b0;
    tick(); chk("w8_e19", 32'(ce), 2'b10);
    tick(); chk("w8_e20", 32'(ce), 2'b01);
    tick(); chk("w8_e21", 32'(ce), 2'b10);

    // ch1 inc=3: exactly 3 pulses in 16 cycles
    wr(1, 3);
    tick(); chk("w3_pend", 32'(pending), 2'b10);
    wr_en = 1'b0;
    tick(); chk("w3_e23_ce1", 32'(ce[1]), 1); chk("w3_applied", 32'(pending), 0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      cnt += int'(ce[1]);
    end
    chk("w3_count16", 32'(cnt), 3);

    // Mid-run ch0 8->4: pending until next pulse, then spacing 4
    wr(0, 4);
    tick(); chk("w4_e40_ce0", 32'(ce[0]), 1); chk("w4_pend_e40", 32'(pending[0]), 1);
    wr_en = 1'b0;
    tick(); chk("w4_pend_e41", 32'(pending[0]), 1); chk("w4_e41_ce0", 32'(ce[0]), 0);
    tick(); chk("w4_e42_ce0", 32'(ce[0]), 1); chk("w4_pend_e42", 32'(pending[0]), 0);

    // Out-of-range channel write is ignored
    wr(5, 0);
    tick(); chk("bad_ch_pend", 32'(pending), 2'b00); chk("w4_e43_ce0", 32'(ce[0]), 0);

    // ch1 to inc=0, then 8 applied the cycle after the write
    wr(1, 0);
    tick(); chk("w0_pend", 32'(pending), 2'b10); chk("w4_e44_ce", 32'(ce), 2'b00);
    wr_en = 1'b0;
    tick(); chk("w0_e45", 32'(ce), 2'b10); chk("w0_applied", 32'(pending), 0);
    tick(); chk("w0_e46", 32'(ce), 2'b01);
    wr(1, 8);
    tick(); chk("idle_pend", 32'(pending), 2'b10); chk("idle_e47", 32'(ce), 2'b00);
    wr_en = 1'b0;
    tick(); chk("idle_applied", 32'(pending), 0); chk("idle_e48", 32'(ce), 2'b00);
    tick(); chk("idle_e49", 32'(ce), 2'b00);
    tick(); chk("idle_e50", 32'(ce), 2'b11);
    tick(); chk("idle_e51", 32'(ce), 2'b00);
    tick(); chk("idle_e52", 32'(ce), 2'b10);

    // Stage ch0=8, then sync on a carry cycle with a same-cycle ch1 write
    wr(0, 8);
    tick(); chk("s_pend_e53", 32'(pending), 2'b01); chk("s_e53", 32'(ce), 2'b00);
    wr(1, 8);
    sync = 1'b1;
    tick(); chk("sync_supp", 32'(ce), 2'b00); chk("sync_pend", 32'(pending), 2'b10);
    wr_en = 1'b0;
    sync  = 1'b0;
    tick(); chk("sync_e55", 32'(ce), 2'b00); chk("sync_pend_e55", 32'(pending), 2'b10);
    tick(); chk("sync_e56", 32'(ce), 2'b11); chk("sync_pend_e56", 32'(pending), 0);
    tick(); chk("sync_e57", 32'(ce), 2'b00);

    // Reset while pending and ce are high
    wr(0, 4);
    tick(); chk("pre_rst_ce", 32'(ce), 2'b11); chk("pre_rst_pend", 32'(pending), 2'b01);
    wr_en = 1'b0;
    rst   = 1'b1;
    tick();
    chk("mid_rst_ce", 32'(ce), 0);
    chk("mid_rst_pend", 32'(pending), 0);
    chk("mid_rst_locked", 32'(locked), 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("relock_r3", 32'(locked), 0);
    tick(); chk("relock_r4", 32'(locked), 1);
    tick(); chk("relock_r5", 32'(ce), 2'b00);
    tick(); chk("relock_r6", 32'(ce), 2'b11);
    tick(); chk("relock_r7", 32'(ce), 2'b00);
    tick(); chk("relock_r8", 32'(ce), 2'b11); chk("relock_pend", 32'(pending), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
